ariscv_wbctl: RTL

- Write-back controller: the writer side of the general register file. It merges ALU and load/store-unit (LSU) results into the register file's single write port (we3/a3/wd3).
- Holds a busy scoreboard of pending destination registers and raises an issue stall for RAW and WAW hazards.
- Sits between the execute stage, the LSU and the register file, in the same clock domain.

---
 rtl/ariscv_wbctl_if.sv | 45 ++++
 rtl/ariscv_wbctl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ariscv_wbctl_if.sv
// Write-back controller bus: issue/hazard handshake, ALU and LSU result
// channels, and the register file write port.
interface ariscv_wbctl_if #(
  parameter int MSB  = 4,
  parameter int REGW = 32
);
  // Decode issue and hazard response
  logic            iss_valid;
  logic [MSB:0]    iss_rs1;
  logic [MSB:0]    iss_rs2;
  logic [MSB:0]    iss_rd;
  logic            iss_stall;

  // ALU result channel (always accepted)
  logic            alu_valid;
  logic [MSB:0]    alu_rd;
  logic [REGW-1:0] alu_data;

  // LSU load result channel (valid/ready)
  logic            lsu_valid;
  logic            lsu_ready;
  logic [MSB:0]    lsu_rd;
  logic [REGW-1:0] lsu_data;

  // Register file write port
  logic            we3;
  logic [MSB:0]    a3;
  logic [REGW-1:0] wd3;

  // Producer side: decode, ALU, LSU and the register file sink
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_stall, lsu_ready, we3, a3, wd3
  );

  // Controller side
  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_stall, lsu_ready, we3, a3, wd3
  );
endinterface

// File: rtl/ariscv_wbctl.sv
// Write-back controller: arbitrates ALU and queued LSU results onto the
// single register file write port and keeps a busy scoreboard of pending
// destinations to stall RAW/WAW hazards at issue.
module ariscv_wbctl #(
  parameter int NREG     = 32,
  parameter int MSB      = 4,
  parameter int REGW     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic           clk,
  input  logic           srst,
  ariscv_wbctl_if.slave  bus
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LQ_FULL = CW'(LQ_DEPTH);

  typedef struct packed {
    logic [MSB:0]    rd;
    logic [REGW-1:0] data;
  } lq_entry_t;

  // LSU result queue
  lq_entry_t       lq_mem_q [LQ_DEPTH];
  lq_entry_t       lq_head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, lsu_rdy;

  // Scoreboard and issue
  logic [NREG-1:0] busy_q, busy_d;
  logic            iss_fire;

  // Registered write port
  logic            we3_q, we3_d;
  logic [MSB:0]    a3_q, a3_d;
  logic [REGW-1:0] wd3_q, wd3_d;

  // Hazard detection: any operand or the destination still pending.
  assign bus.iss_stall = bus.iss_valid &
                         (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | busy_q[bus.iss_rd]);
  assign iss_fire      = bus.iss_valid & ~bus.iss_stall & (bus.iss_rd != '0);

  // The ready flag ignores a same-cycle pop, so a full queue never accepts.
  assign lsu_rdy       = ~srst & (count_q < LQ_FULL);
  assign bus.lsu_ready = lsu_rdy;
  assign push          = bus.lsu_valid & lsu_rdy;
  assign pop           = ~bus.alu_valid & (count_q != '0);
  assign lq_head       = lq_mem_q[rd_ptr_q];

  assign bus.we3 = we3_q;
  assign bus.a3  = a3_q;
  assign bus.wd3 = wd3_q;

  // Scoreboard next state: clear the register being written, then set the
  // newly issued destination so a coincident set wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    busy_d = busy_q;
    if (we3_q)    busy_d[a3_q]       = 1'b0;
    if (iss_fire) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Write selection: ALU first, then the queue head; otherwise hold a3/wd3.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (bus.alu_valid) begin
      we3_d = (bus.alu_rd != '0);
      a3_d  = bus.alu_rd;
      wd3_d = bus.alu_data;
    end else if (pop) begin
      we3_d = (lq_head.rd != '0);
      a3_d  = lq_head.rd;
      wd3_d = lq_head.data;
    end
  end

  // Queue pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Queue storage: only the pointers and count define emptiness.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately left out of reset; a zeroed
    // count makes stale contents unreachable and keeps this a plain RAM.
    if (push) lq_mem_q[wr_ptr_q] <= {bus.lsu_rd, bus.lsu_data};
  end

  // Control state with synchronous reset overriding all events.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (srst) begin
      busy_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

endmodule
